// File: rtl/mc_request_queue.sv
// mc_request_queue: time-gated 16-deep in-order request FIFO that owns and fast-forwards the CPU cycle counter
module mc_request_queue #(
  parameter int ADDR_WIDTH  = 36,
  parameter int MEMOP_WIDTH = 2,
  parameter int TIME_WIDTH  = 64,
  parameter int IN_BUFF_CT  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [TIME_WIDTH-1:0]           in_time,
  input  logic [MEMOP_WIDTH-1:0]          in_op,
  input  logic [ADDR_WIDTH-1:0]           in_addr,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [TIME_WIDTH-1:0]           out_time,
  output logic [MEMOP_WIDTH-1:0]          out_op,
  output logic [ADDR_WIDTH-1:0]           out_addr,
  output logic [$clog2(IN_BUFF_CT):0]     count,
  output logic                            full,
  output logic                            empty,
  output logic [TIME_WIDTH-1:0]           cpu_time,
  output logic                            err_order,
  output logic                            err_op
);
  localparam int PW = $clog2(IN_BUFF_CT);
  localparam int CW = PW + 1;
  logic [TIME_WIDTH-1:0]  mem_time [IN_BUFF_CT];
  logic [MEMOP_WIDTH-1:0] mem_op   [IN_BUFF_CT];
  logic [ADDR_WIDTH-1:0]  mem_addr [IN_BUFF_CT];
  logic [PW-1:0]          head, tail;
  logic [TIME_WIDTH-1:0]  last_time;
  logic [CW-1:0]          count_nxt;
  logic                   push, store, pop, bad_op;
  assign in_ready  = !rst && !full && (in_time <= cpu_time);
  assign push      = in_valid && in_ready;
  assign bad_op    = in_op == MEMOP_WIDTH'(3);
  assign store     = push && !bad_op;
  assign pop       = !empty && out_ready;
  assign out_valid = !empty;
  assign out_time  = mem_time[head];
  assign out_op    = mem_op[head];
  assign out_addr  = mem_addr[head];
  always_comb count_nxt = count + CW'(store) - CW'(pop);
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < IN_BUFF_CT; i++) begin
        mem_time[i] <= '0;
        mem_op[i]   <= '0;
        mem_addr[i] <= '0;
      end
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      cpu_time  <= '0;
      last_time <= '0;
      err_order <= 1'b0;
      err_op    <= 1'b0;
    end else begin
      cpu_time <= (empty && in_valid && in_time > cpu_time) ? in_time : cpu_time + 1'b1;
      if (store) begin
        mem_time[tail] <= in_time;
        mem_op[tail]   <= in_op;
        mem_addr[tail] <= in_addr;
        tail           <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      if (push) last_time <= in_time;
      count     <= count_nxt;
      full      <= count_nxt == CW'(IN_BUFF_CT);
      empty     <= count_nxt == '0;
      err_order <= err_order | (push && in_time < last_time);
      err_op    <= err_op | (push && bad_op);
    end
  end
endmodule

// File: tb/tb_mc_request_queue.sv
// tb_mc_request_queue: directed self-checking bench for mc_request_queue
module tb_mc_request_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_time = '0;
  logic [1:0]  in_op = '0;
  logic [35:0] in_addr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_time;
  logic [1:0]  out_op;
  logic [35:0] out_addr;
  logic [4:0]  count;
  logic        full, empty;
  logic [63:0] cpu_time;
  logic        err_order, err_op;
  int n_checks = 0;
  int n_fail = 0;
  mc_request_queue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_time(in_time),
    .in_op(in_op), .in_addr(in_addr), .out_valid(out_valid), .out_ready(out_ready),
    .out_time(out_time), .out_op(out_op), .out_addr(out_addr), .count(count), .full(full),
    .empty(empty), .cpu_time(cpu_time), .err_order(err_order), .err_op(err_op)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [63:0] t, input logic [1:0] op, input logic [35:0] a);
    in_valid = 1'b1;
    in_time  = t;
    in_op    = op;
    in_addr  = a;
    #1;
    for (int i = 0; i < 200 && !in_ready; i++) step();
    if (!in_ready) check("push_timeout", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    step();
    step();
    check("rst_cpu", cpu_time, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovalid", out_valid, 0);
    check("rst_iready", in_ready, 0);
    check("rst_oaddr", out_addr, 0);
    check("rst_eord", err_order, 0);
    check("rst_eop", err_op, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    step();
    check("cpu_after_rst", cpu_time, 1);
    repeat (4) step();
    check("cpu_5", cpu_time, 5);
    in_valid = 1'b1;
    in_time  = 100;
    in_op    = 0;
    in_addr  = 36'h01FF97000;
    #1;
    check("ff_gate", in_ready, 0);
    step();
    check("ff_cpu", cpu_time, 100);
    check("ff_ready", in_ready, 1);
    check("ff_count0", count, 0);
    step();
    in_valid = 1'b0;
    check("ff_count1", count, 1);
    check("ff_ovalid", out_valid, 1);
    check("ff_oaddr", out_addr, 36'h01FF97000);
    check("ff_otime", out_time, 100);
    check("ff_cpu101", cpu_time, 101);
    in_valid = 1'b1;
    in_time  = 104;
    in_op    = 1;
    in_addr  = 36'h55;
    #1;
    check("gate_0", in_ready, 0);
    for (int k = 1; k < 3; k++) begin
      step();
      check("gate_wait", in_ready, 0);
    end
    step();
    check("gate_open", in_ready, 1);
    check("gate_cnt1", count, 1);
    step();
    in_valid = 1'b0;
    check("gate_cnt2", count, 2);
    out_ready = 1'b1;
    check("drain_a0", out_addr, 36'h01FF97000);
    step();
    check("drain_a1", out_addr, 36'h55);
    check("drain_op1", out_op, 1);
    check("drain_c1", count, 1);
    step();
    check("drain_c0", count, 0);
    check("drain_empty", empty, 1);
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_time  = 0;
      in_op    = 0;
      in_addr  = 36'(i);
      step();
    end
    in_addr = 36'd16;
    check("full_cnt", count, 16);
    check("full_flag", full, 1);
    #1;
    check("full_nready", in_ready, 0);
    step();
    check("full_nready2", in_ready, 0);
    check("full_cnt2", count, 16);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("pop_order", out_addr, 64'(k));
      step();
      if (k == 0) check("pop_ready17", in_ready, 1);
      if (k == 1) begin
        in_valid = 1'b0;
        check("pop_pushcnt", count, 15);
      end
    end
    check("pop_left", count, 1);
    check("pop_a16", out_addr, 16);
    check("pop_eord", err_order, 0);
    in_valid = 1'b1;
    in_time  = 0;
    in_addr  = 36'h77;
    step();
    in_valid = 1'b0;
    check("sim_cnt", count, 1);
    check("sim_addr", out_addr, 36'h77);
    step();
    check("sim_empty", empty, 1);
    check("sim_cnt0", count, 0);
    out_ready = 1'b0;
    push(50, 0, 36'hA);
    push(40, 1, 36'hB);
    check("eord_set", err_order, 1);
    check("eord_cnt", count, 2);
    check("eop_clear", err_op, 0);
    push(60, 3, 36'hC);
    check("eop_set", err_op, 1);
    check("eop_cnt", count, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_cnt", count, 0);
    check("mrst_empty", empty, 1);
    check("mrst_eord", err_order, 0);
    check("mrst_eop", err_op, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
